// File: rtl/bicubic_frame_streamer.sv
// Streams one frame from a synchronous frame memory in raster order over valid/ready,
// tagging the first pixel (sof) and each line's last pixel (eol).
module bicubic_frame_streamer #(
    parameter int CH_WIDTH   = 8,
    parameter int CHANNELS   = 3,
    parameter int MAX_WIDTH  = 960,
    parameter int MAX_HEIGHT = 540,
    parameter int ADDR_WIDTH = 20,
    parameter int PW         = CH_WIDTH * CHANNELS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [15:0]           i_cfg_width,
    input  logic [15:0]           i_cfg_height,
    input  logic                  i_cfg_bottom_up,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
    input  logic [PW-1:0]         i_mem_rd_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [PW-1:0]         o_m_data,
    output logic                  o_m_sof,
    output logic                  o_m_eol,
    output logic [2:0]            o_dbg_state
);

    // Handshake: a pixel transfers on a cycle where o_m_valid && i_m_ready; once
    // o_m_valid is high it and the payload hold until that transfer happens.

    if ((64'd1 << ADDR_WIDTH) < 64'(MAX_WIDTH) * 64'(MAX_HEIGHT)) begin : g_addr_check
        $error("ADDR_WIDTH too small for MAX_WIDTH*MAX_HEIGHT");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state, w_next;
    logic [15:0]           r_width, r_height, r_col, r_row;
    logic                  r_bottom_up;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic                  r_inflight, r_pend_sof, r_pend_eol;
    logic                  r_head_v, r_head_sof, r_head_eol;
    logic [PW-1:0]         r_head_data;
    logic                  r_skid_v, r_skid_sof, r_skid_eol;
    logic [PW-1:0]         r_skid_data;

    logic                  w_pop, w_issue, w_last_col, w_last_row;
    logic [1:0]            w_occ, w_occ_after;
    logic [ADDR_WIDTH-1:0] w_setup_base;

    assign w_pop        = r_head_v & i_m_ready;
    assign w_occ        = {1'b0, r_head_v} + {1'b0, r_skid_v} + {1'b0, r_inflight};
    // Occupancy after this cycle's pop lets a read overlap a drain, keeping 1 pixel/cycle.
    assign w_occ_after  = w_occ - {1'b0, w_pop};
    assign w_issue      = (r_state == S_RUN) && !(r_head_v && r_skid_v) && (w_occ_after < 2'd2);
    assign w_last_col   = (r_col == r_width - 16'd1);
    assign w_last_row   = (r_row == r_height - 16'd1);
    assign w_setup_base = ADDR_WIDTH'(r_height - 16'd1) * ADDR_WIDTH'(r_width);

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_FINISH);
    assign o_mem_rd_en   = w_issue;
    assign o_mem_rd_addr = r_row_base + ADDR_WIDTH'(r_col);
    assign o_m_valid     = r_head_v;
    assign o_m_data      = r_head_data;
    assign o_m_sof       = r_head_sof;
    assign o_m_eol       = r_head_eol;
    assign o_dbg_state   = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_SETUP;
            S_SETUP:  w_next = (r_width == 16'd0 || r_height == 16'd0) ? S_FINISH : S_RUN;
            S_RUN:    if (w_issue && w_last_col && w_last_row) w_next = S_DRAIN;
            S_DRAIN:  if (w_occ_after == 2'd0) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_width     <= '0;
            r_height    <= '0;
            r_bottom_up <= 1'b0;
            r_row_base  <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_inflight  <= 1'b0;
            r_pend_sof  <= 1'b0;
            r_pend_eol  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_width     <= i_cfg_width;
                r_height    <= i_cfg_height;
                r_bottom_up <= i_cfg_bottom_up;
            end
            if (r_state == S_SETUP) begin
                r_row_base <= r_bottom_up ? w_setup_base : '0;
                r_col      <= '0;
                r_row      <= '0;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pend_sof <= (r_row == 16'd0) && (r_col == 16'd0);
                r_pend_eol <= w_last_col;
                if (w_last_col) begin
                    r_col      <= '0;
                    r_row      <= r_row + 16'd1;
                    r_row_base <= r_bottom_up ? r_row_base - ADDR_WIDTH'(r_width)
                                              : r_row_base + ADDR_WIDTH'(r_width);
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end
        end
    end

    // Two-entry FIFO: head drives the outputs directly, skid absorbs one stalled arrival.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head_v    <= 1'b0;
            r_head_data <= '0;
            r_head_sof  <= 1'b0;
            r_head_eol  <= 1'b0;
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
            r_skid_sof  <= 1'b0;
            r_skid_eol  <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_v) begin
                r_head_data <= r_skid_data;
                r_head_sof  <= r_skid_sof;
                r_head_eol  <= r_skid_eol;
                if (r_inflight) begin
                    r_skid_data <= i_mem_rd_data;
                    r_skid_sof  <= r_pend_sof;
                    r_skid_eol  <= r_pend_eol;
                end else begin
                    r_skid_v <= 1'b0;
                end
            end else if (r_inflight) begin
                r_head_data <= i_mem_rd_data;
                r_head_sof  <= r_pend_sof;
                r_head_eol  <= r_pend_eol;
            end else begin
                r_head_v <= 1'b0;
            end
        end else if (r_inflight) begin
            if (!r_head_v) begin
                r_head_v    <= 1'b1;
                r_head_data <= i_mem_rd_data;
                r_head_sof  <= r_pend_sof;
                r_head_eol  <= r_pend_eol;
            end else begin
                r_skid_v    <= 1'b1;
                r_skid_data <= i_mem_rd_data;
                r_skid_sof  <= r_pend_sof;
                r_skid_eol  <= r_pend_eol;
            end
        end
    end

endmodule

// File: tb/tb_bicubic_frame_streamer.sv
// Randomised scoreboard bench for bicubic_frame_streamer against a raster-order frame model.
module tb_bicubic_frame_streamer;
  localparam int PW = 24;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst, start, cfg_bu;
  logic [15:0]   cfg_w, cfg_h;
  logic          busy, done, rd_en, m_valid, m_ready, m_sof, m_eol;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data, m_data;
  logic [2:0]    dbg_state;

  bicubic_frame_streamer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_cfg_width(cfg_w), .i_cfg_height(cfg_h), .i_cfg_bottom_up(cfg_bu),
    .o_busy(busy), .o_done(done), .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr),
    .i_mem_rd_data(rd_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_data(m_data), .o_m_sof(m_sof), .o_m_eol(m_eol), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [PW+1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int done_cnt = 0, rd_cnt = 0, valid_cnt = 0, busy_cnt = 0, hs_cnt = 0;
  int last_hs_cyc = 0, occ = 0, ready_mode = 0, phase = 0;
  bit expect_pixels = 0, prev_stall = 0;
  logic [PW+1:0] prev_word;

  function automatic logic [PW-1:0] pix(input logic [AW-1:0] a);
    logic [PW-1:0] a_ext;
    a_ext = PW'(a);
    return a_ext * 24'h010101;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // frame memory: data valid one cycle after the read strobe, junk otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= pix(rd_addr);
    else       rd_data <= PW'($urandom);
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = (phase == 0 || phase == 3); phase = (phase + 1) % 4; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      occ = 0;
    end else begin
      if (rd_en) begin
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
        check("rd_occupancy", 64'((occ + 1 - int'(m_valid && m_ready)) <= 2), 64'd1);
        rd_cnt++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_payload", 64'({m_sof, m_eol, m_data}), 64'(prev_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_pixel");
        else check("pixel", 64'({m_sof, m_eol, m_data}), 64'(exp_q.pop_front()));
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      occ = occ + int'(rd_en) - int'(m_valid && m_ready);
      if (m_valid) valid_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (expect_pixels) check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_sof, m_eol, m_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: raster order, bottom-up frames read memory rows in reverse
  task automatic push_model(input int w, input int h, input bit bu);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int mrow;
        logic [AW-1:0] a;
        mrow = bu ? (h - 1 - r) : r;
        a = AW'(mrow * w + c);
        addr_q.push_back(a);
        exp_q.push_back({(r == 0 && c == 0), (c == w - 1), pix(a)});
      end
    end
  endtask

  task automatic issue_start(input int w, input int h, input bit bu);
    cfg_w  = 16'(w);
    cfg_h  = 16'(h);
    cfg_bu = bu;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cfg_w  = 16'($urandom_range(1, 20));
    cfg_h  = 16'($urandom_range(1, 20));
    cfg_bu = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input int w, input int h, input bit bu, input bit restart, input bit lat_check);
    int d0, n;
    expect_pixels = (w != 0 && h != 0);
    push_model(w, h, bu);
    d0 = done_cnt;
    issue_start(w, h, bu);
    if (lat_check) begin
      for (int i = 1; i <= 3; i++) begin
        tick();
        check("first_valid_latency", 64'(m_valid), 64'(i == 3));
      end
    end
    if (restart) begin
      repeat (3) tick();
      issue_start(1, 1, 0);
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail_now("done_timeout");
    repeat (3) tick();
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("pixels_left", 64'(exp_q.size()), 64'd0);
    check("reads_left", 64'(addr_q.size()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
    check({tag, "_m_sof"}, 64'(m_sof), 64'd0);
    check({tag, "_m_eol"}, 64'(m_eol), 64'd0);
  endtask

  initial begin
    int b0, r0, v0, d0, h0, n;
    rst = 1'b1; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_bu = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    ready_mode = 0;
    run_frame(4, 2, 0, 0, 1);
    run_frame(4, 2, 1, 0, 1);

    ready_mode = 1;
    phase = 0;
    run_frame(3, 3, 0, 0, 0);

    ready_mode = 0;
    b0 = busy_cnt; r0 = rd_cnt; v0 = valid_cnt;
    run_frame(0, 5, 0, 0, 0);
    check("zero_busy_cycles", 64'(busy_cnt - b0), 64'd2);
    check("zero_reads", 64'(rd_cnt - r0), 64'd0);
    check("zero_valid", 64'(valid_cnt - v0), 64'd0);

    run_frame(4, 2, 0, 1, 0);

    // abort a 4x4 frame after three pixels
    d0 = done_cnt;
    h0 = hs_cnt;
    push_model(4, 4, 0);
    expect_pixels = 1;
    issue_start(4, 4, 0);
    n = 0;
    while (hs_cnt - h0 < 3 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now("abort_wait_timeout");
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (4) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(4, 4, 0, 0, 1);

    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      run_frame($urandom_range(1, 12), $urandom_range(1, 8), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
